mul_feeder: RTL and testbench
=============================

# mul_feeder

Operand queue placed directly upstream of the `mul` sequential multiplier. It accepts operand pairs from a producer on a valid/ready handshake and buffers them in a small FIFO. It presents each pair to `mul` through that block's `wr_en`/`wr_ready` write port, so producers never stall on the multiplier's multi-cycle busy window.

## Interface
Parameters:
- DATA_WIDTH, 32, operand width; must match `mul` DATA_WIDTH.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; clears all state immediately on assertion.
- in_valid  in  1  producer offers the pair in_a/in_b.
- in_a  in  DATA_WIDTH  first operand.
- in_b  in  DATA_WIDTH  second operand.
- in_ready  out  1  FIFO can accept; equals !full.
- wr_ready  in  1  `mul` can accept a pair this cycle.
- wr_en  out  1  pair on wr_data_1/wr_data_2 is valid; transfer when wr_en && wr_ready at clk edge.
- wr_data_1  out  DATA_WIDTH  operand to `mul` port 1 (from in_a).
- wr_data_2  out  DATA_WIDTH  operand to `mul` port 2 (from in_b).
- count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
- overflow  out  1  sticky; set when in_valid && !in_ready.

## Operation
- Push: in_valid && in_ready at edge → pair written at wr_ptr, wr_ptr++, count++.
- Pop: wr_en && wr_ready at edge → rd_ptr++, count--.
- wr_en = !empty && wr_ready (combinational). wr_data_* = head entry when wr_en, else 0. No X ever leaves the block.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: in_ready=0. A push offered while full is dropped, and overflow is set. A pop in the same cycle does not make in_ready high; there is no combinational wr_ready→in_ready path.
- Empty: wr_en=0 and the outputs are 0, regardless of wr_ready.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Full and empty are derived from count.
- FIFO order is strict; pairs reach `mul` in acceptance order.
- overflow clears only on reset.
- Reset mid-operation flushes all queued pairs. Pointers, count and overflow go to 0. Memory contents are not reset.

## Timing
Reset values: in_ready=1, wr_en=0, wr_data_1=wr_data_2=0, count=0, overflow=0.
- Latency without bypass: a pair accepted at edge N drives wr_en in cycle N+1 if wr_ready=1.
- Throughput: one push and one pop per cycle.
- Outputs depend combinationally on wr_ready only. in_ready and count are functions of registered state.

## Configuration
- MUL_FEEDER_BYPASS_EN defined:
  - When the FIFO is empty and in_valid && wr_ready, the pair passes straight through in the same cycle: wr_en=1, wr_data_1=in_a, wr_data_2=in_b.
  - Nothing is stored and count stays 0.
  - This adds an in_valid→wr_en combinational path.
- MUL_FEEDER_BYPASS_EN undefined: every pair goes through storage, with the 1-cycle minimum latency.

## Structure
- Shared package `mul_pkg` holds:
  - DATA_WIDTH, RES_WIDTH, PART_DATA_WIDTH defaults (32/64/8);
  - typedef `mul_operands_t` (struct {a, b} of DATA_WIDTH each);
  - the pointer-width helper constant.
- One sub-module, `mul_feeder_fifo`: synchronous storage plus pointers and count, parameterised on DEPTH and entry width.
- The top level adds the handshake gating, output zeroing, overflow and the optional bypass.

## Test plan
1. Reset low for 2 cycles → in_ready=1, wr_en=0, count=0, overflow=0, wr_data_*=0.
2. With wr_ready=0, push 4 pairs (1,2),(3,4),(5,6),(7,8), then offer a 5th (9,10):
   - count=4, in_ready=0, overflow=1;
   - then wr_ready=1 for 4 cycles → `mul` receives exactly (1,2),(3,4),(5,6),(7,8) in order, count=0.
3. With wr_ready=1, push 0x123456/0x123456 in one cycle and nothing else:
   - without the macro, wr_en=1 one cycle later with both operands 0x123456;
   - with MUL_FEEDER_BYPASS_EN, wr_en=1 in the same cycle and count stays 0.
4. Continuous push with wr_ready=1, starting from 2 queued entries → count holds at 2 for 10 cycles, order preserved, pointers wrap past DEPTH-1.
5. Assert reset while count=3 → count=0, wr_en=0 immediately (async). After release, the next pushed pair is the first one delivered.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared widths, operand pair type and pointer-width helper for mul and its feeder
//   DATA_WIDTH / RES_WIDTH / PART_DATA_WIDTH : default operand, result and partial-product widths
//   mul_operands_t                           : {a, b} operand pair as seen by mul
//   FEEDER_DEPTH / FEEDER_PTR_WIDTH          : default feeder depth and its pointer width
package mul_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int RES_WIDTH = 64;
  localparam int PART_DATA_WIDTH = 8;
  localparam int FEEDER_DEPTH = 4;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } mul_operands_t;
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction
  localparam int FEEDER_PTR_WIDTH = ptr_width(FEEDER_DEPTH);
endpackage

// File: rtl/mul_feeder_fifo.sv
// mul_feeder_fifo: circular-buffer storage with read/write pointers and occupancy count
//   clk, reset (async, active-low)
//   push_i/wdata_i : write wdata_i at the tail (caller guarantees !full_o)
//   pop_i          : retire the head entry (caller guarantees !empty_o)
//   rdata_o        : head entry; count_o/full_o/empty_o : occupancy status
module mul_feeder_fifo
  import mul_pkg::*;
#(
  parameter int WIDTH = 2 * DATA_WIDTH,
  parameter int DEPTH = FEEDER_DEPTH,
  localparam int PW = ptr_width(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  // storage is deliberately left out of reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
endmodule

// File: rtl/mul_feeder.sv
// mul_feeder: operand-pair FIFO feeding the mul write port so producers never stall on mul busy
//   clk, reset (async, active-low)
//   in_valid/in_a/in_b/in_ready : producer handshake (in_ready = !full)
//   wr_ready/wr_en/wr_data_1/wr_data_2 : mul write port; data is zero whenever wr_en is low
//   count : occupied entries; overflow : sticky, set by an offer while full
//   MUL_FEEDER_BYPASS_EN : when defined, an empty FIFO passes a pair straight to mul in the same cycle
module mul_feeder
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = mul_pkg::DATA_WIDTH,
  parameter int DEPTH = FEEDER_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_a,
  input  logic [DATA_WIDTH-1:0]       in_b,
  output logic                        in_ready,
  input  logic                        wr_ready,
  output logic                        wr_en,
  output logic [DATA_WIDTH-1:0]       wr_data_1,
  output logic [DATA_WIDTH-1:0]       wr_data_2,
  output logic [ptr_width(DEPTH):0]   count,
  output logic                        overflow
);
  logic [2*DATA_WIDTH-1:0] head;
  logic full, empty, push, pop, overflow_q, overflow_d;
  mul_feeder_fifo #(.WIDTH(2 * DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push_i(push),
    .pop_i(pop),
    .wdata_i({in_a, in_b}),
    .rdata_o(head),
    .count_o(count),
    .full_o(full),
    .empty_o(empty)
  );
  // registered-only: a same-cycle pop never reopens a full FIFO
  assign in_ready = !full;
`ifdef MUL_FEEDER_BYPASS_EN
  // an empty FIFO with mul ready forwards the offered pair instead of storing it
  always_comb begin
    wr_en = (!empty || in_valid) && wr_ready;
    {wr_data_1, wr_data_2} = !wr_en ? '0 : empty ? {in_a, in_b} : head;
    push = in_valid && in_ready && !(empty && wr_ready);
    pop = wr_en && !empty;
  end
`else
  always_comb begin
    wr_en = !empty && wr_ready;
    {wr_data_1, wr_data_2} = wr_en ? head : '0;
    push = in_valid && in_ready;
    pop = wr_en;
  end
`endif
  assign overflow_d = overflow_q || (in_valid && !in_ready);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow_q <= 1'b0;
    else overflow_q <= overflow_d;
  end
  assign overflow = overflow_q;
endmodule

// File: tb/tb_mul_feeder.sv
// tb_mul_feeder: directed scoreboard bench for mul_feeder
module tb_mul_feeder;
  import mul_pkg::*;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic wr_ready = 1'b0;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic in_ready, wr_en, overflow;
  logic [DW-1:0] wr_data_1, wr_data_2;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;
  mul_operands_t sb[$];
  always #5 clk = ~clk;
  mul_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_ready(in_ready), .wr_ready(wr_ready), .wr_en(wr_en),
    .wr_data_1(wr_data_1), .wr_data_2(wr_data_2), .count(count), .overflow(overflow)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic offer(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit accept);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    if (accept) sb.push_back('{a: a, b: b});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // monitor: every transfer to mul must match the scoreboard head; idle port must be all zero
  always @(negedge clk) begin
    if (reset) begin
      if (wr_en && wr_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pair got %0h/%0h expected none", wr_data_1, wr_data_2);
        end else begin
          mul_operands_t e;
          e = sb.pop_front();
          check("pair", {wr_data_1, wr_data_2}, {e.a, e.b});
        end
      end else begin
        check("idle_port", {31'd0, wr_en, wr_data_1, wr_data_2}, 64'd0);
      end
    end
  end
  initial begin
    wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_data", {wr_data_1, wr_data_2}, 64'd0);
    tick();
    reset = 1'b1;
    // fill while mul is busy, then overflow
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(DW'(2 * i + 1), DW'(2 * i + 2), 1'b1);
      tick();
    end
    offer(32'd9, 32'd10, 1'b0);
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_count", 64'(count), 64'd4);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("overflow_set", 64'(overflow), 64'd1);
    check("full_count_kept", 64'(count), 64'd4);
    tick();
    wr_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("drain_count", 64'(count), 64'd0);
    check("drain_sb", 64'(sb.size()), 64'd0);
    tick();
    // single pair latency
    offer(32'h123456, 32'h123456, 1'b1);
    @(negedge clk);
`ifdef MUL_FEEDER_BYPASS_EN
    check("lat_same_cycle_wr_en", 64'(wr_en), 64'd1);
`else
    check("lat_same_cycle_wr_en", 64'(wr_en), 64'd0);
`endif
    check("lat_same_cycle_count", 64'(count), 64'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
`ifdef MUL_FEEDER_BYPASS_EN
    check("lat_next_wr_en", 64'(wr_en), 64'd0);
    check("lat_next_count", 64'(count), 64'd0);
`else
    check("lat_next_wr_en", 64'(wr_en), 64'd1);
    check("lat_next_count", 64'(count), 64'd1);
`endif
    tick();
    check("lat_sb", 64'(sb.size()), 64'd0);
    // steady state: two queued, push and pop every cycle, pointers wrap
    wr_ready = 1'b0;
    offer(32'd100, 32'd101, 1'b1);
    tick();
    offer(32'd102, 32'd103, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("steady_pre_count", 64'(count), 64'd2);
    tick();
    wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(DW'(200 + 2 * i), DW'(201 + 2 * i), 1'b1);
      @(negedge clk);
      check("steady_count", 64'(count), 64'd2);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("steady_drain_count", 64'(count), 64'd0);
    check("steady_sb", 64'(sb.size()), 64'd0);
    tick();
    // asynchronous reset while three entries are queued
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(DW'(300 + i), DW'(400 + i), 1'b1);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_count", 64'(count), 64'd3);
    #1;
    wr_ready = 1'b1;
    reset = 1'b0;
    sb.delete();
    #1;
    check("async_count", 64'(count), 64'd0);
    check("async_wr_en", 64'(wr_en), 64'd0);
    check("async_overflow", 64'(overflow), 64'd0);
    tick();
    reset = 1'b1;
    offer(32'hAAAA, 32'h5555, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("post_reset_sb", 64'(sb.size()), 64'd0);
    check("post_reset_count", 64'(count), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
